uarttx_arbiter: RTL

Round-robin arbiter and sequencer that shares one `uarttx` transmitter between `NumPorts` byte producers, such as the CPU console path and the debug/trace path. It accepts one byte per grant over a valid/ready interface and holds that byte stable for the whole frame. It drives the transmitter's level-sensitive `go`/`bsy` handshake, including the mandatory `go`-low acknowledge. A watchdog recovers if the transmitter never raises `bsy`.

---
 rtl/uarttx_arbiter_if.sv | 27 ++
 rtl/uarttx_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/uarttx_arbiter_if.sv
// Byte-producer and transmitter-side signals of uarttx_arbiter.
// The slave modport is the arbiter; the master modport is the producers plus the transmitter.
interface uarttx_arbiter_if #(
  parameter int unsigned NumPorts = 2
) ();
  localparam int unsigned IdW = $clog2(NumPorts);

  logic [NumPorts-1:0]   req_valid;
  logic [8*NumPorts-1:0] req_data;
  logic [NumPorts-1:0]   req_ready;
  logic [7:0]            tx_data;
  logic                  tx_go;
  logic                  tx_bsy;
  logic [IdW-1:0]        grant_id;
  logic                  busy;
  logic                  timeout;

  modport slave (
    input  req_valid, req_data, tx_bsy,
    output req_ready, tx_data, tx_go, grant_id, busy, timeout
  );

  modport master (
    output req_valid, req_data, tx_bsy,
    input  req_ready, tx_data, tx_go, grant_id, busy, timeout
  );
endinterface

// File: rtl/uarttx_arbiter.sv
// Round-robin sharing of one uarttx between NumPorts byte producers, driving the go/bsy
// handshake with its go-low acknowledge and a watchdog for a transmitter that never goes busy.
module uarttx_arbiter #(
  parameter int unsigned NumPorts   = 2,
  parameter int unsigned BsyTimeout = 16
) (
  input logic            clk,
  input logic            rst_n,
  uarttx_arbiter_if.slave bus
);
  localparam int unsigned IdW = $clog2(NumPorts);
  localparam int unsigned WdW = $clog2(BsyTimeout);
  localparam logic [IdW-1:0] LastPort = IdW'(NumPorts - 1);
  localparam logic [WdW-1:0] WdLast   = WdW'(BsyTimeout - 1);

  typedef enum logic [1:0] {StIdle, StWaitBsyHigh, StWaitBsyLow, StRelease} state_e;

  state_e         state_q;
  logic [7:0]     tx_data_q;
  logic           tx_go_q;
  logic           timeout_q;
  logic [IdW-1:0] grant_id_q;
  logic [IdW-1:0] rr_ptr_q;
  logic [WdW-1:0] wd_cnt_q;
  logic [IdW-1:0] gnt_idx;
  logic           gnt_found;

  // Search upward from the port after the last served one, wrapping by compare.
  always_comb begin : arb
    logic [IdW-1:0] idx;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    idx       = rr_ptr_q;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      idx = (idx == LastPort) ? '0 : idx + 1'b1;
      if (!gnt_found && bus.req_valid[idx]) begin
        gnt_idx   = idx;
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == StIdle && gnt_found) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tx_data_q  <= 8'h00;
      tx_go_q    <= 1'b0;
      timeout_q  <= 1'b0;
      grant_id_q <= '0;
      rr_ptr_q   <= LastPort;
      wd_cnt_q   <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (gnt_found) begin
            tx_data_q  <= bus.req_data[8*gnt_idx +: 8];
            tx_go_q    <= 1'b1;
            grant_id_q <= gnt_idx;
            rr_ptr_q   <= gnt_idx;
            wd_cnt_q   <= '0;
            state_q    <= StWaitBsyHigh;
          end
        end
        StWaitBsyHigh: begin
          if (bus.tx_bsy) begin
            state_q <= StWaitBsyLow;
          end else if (wd_cnt_q == WdLast) begin
            // Transmitter never accepted the byte; drop it rather than retry.
            tx_go_q   <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StRelease;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        StWaitBsyLow: begin
          if (!bus.tx_bsy) begin
            tx_go_q <= 1'b0;
            state_q <= StRelease;
          end
        end
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_go    = tx_go_q;
  assign bus.grant_id = grant_id_q;
  assign bus.timeout  = timeout_q;
  assign bus.busy     = (state_q != StIdle);
endmodule
